lsu_mem_align: RTL and testbench

LSU_MEM_ALIGN -- requirements
Module: lsu_mem_align

---
 rtl/lsu_mem_align.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_mem_align.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_align.sv
// lsu_mem_align
//
// Load/store alignment unit that sits between a single-issue LSU request
// port and a 32-bit byte-lane data memory with a one-cycle synchronous read.
// Each request is handled in three steps:
//   - IDLE:   accept the request.
//   - ACCESS: drive the address, and for stores the write data and lanes.
//   - RESP:   present formatted load data or the error flag until consumed.
//
// Parameters
//   ADDRESS_WIDTH  memory word-address width; byte address is ADDRESS_WIDTH+2
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_store, req_funct3         1=store; RISC-V width code B/H/W/BU/HU
//   req_addr, req_wdata           byte address, right-aligned store data
//   resp_valid/resp_ready         response handshake
//   resp_data, resp_err           formatted load data, access error flag
//   mem_byteEnable, mem_addr      per-lane write enable, word address
//   mem_din, mem_dout             lane-replicated write data, read data
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned H/W accesses are
//                         reported through resp_err and perform no access.
//                         When undefined, the low address bits are cleared
//                         so the access is aligned down and proceeds.
//                         Illegal width codes error in both builds.
module lsu_mem_align #(
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_data,
  output logic                     resp_err,
  output logic [3:0]               mem_byteEnable,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [31:0]              mem_din,
  input  logic [31:0]              mem_dout
);

  localparam int AW = ADDRESS_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          store_p0;
  logic [2:0]    funct3_p0;
  logic [AW-1:0] addr_p0;
  logic [31:0]   wdata_p0;
  logic          err_p0;

  logic [1:0]    req_off;
  logic          req_err;

  // Only 000/001/010 are legal for stores; loads add the unsigned 100/101.
  function automatic logic illegal_f(input logic store, input logic [2:0] f3);
    logic ill;
    case (f3)
      3'b000, 3'b001, 3'b010: ill = 1'b0;
      3'b100, 3'b101:         ill = store;
      default:                ill = 1'b1;
    endcase
    return ill;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned_f(input logic [1:0] sz, input logic [1:0] off);
    logic mis;
    case (sz)
      2'b01:   mis = off[0];
      2'b10:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction
`else
  function automatic logic [1:0] align_f(input logic [1:0] sz, input logic [1:0] off);
    logic [1:0] a;
    case (sz)
      2'b01:   a = {off[1], 1'b0};
      2'b10:   a = 2'b00;
      default: a = off;
    endcase
    return a;
  endfunction
`endif

  function automatic logic [3:0] store_be_f(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Write data is replicated across lanes so the byte enables alone pick
  // the destination; no shifting by offset is needed.
  function automatic logic [31:0] store_din_f(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_fmt_f(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] dout);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = dout[{off, 3'b000} +: 8];
    h = off[1] ? dout[31:16] : dout[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = dout;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = illegal_f(req_store, req_funct3) |
                   misaligned_f(req_funct3[1:0], req_addr[1:0]);
  assign req_off = req_addr[1:0];
`else
  assign req_err = illegal_f(req_store, req_funct3);
  assign req_off = align_f(req_funct3[1:0], req_addr[1:0]);
`endif

  // ---- stage p0: request captured on acceptance, held through ACCESS/RESP ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      store_p0  <= 1'b0;
      funct3_p0 <= 3'b000;
      addr_p0   <= '0;
      wdata_p0  <= '0;
      err_p0    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        store_p0  <= req_store;
        funct3_p0 <= req_funct3;
        addr_p0   <= {req_addr[AW-1:2], req_off};
        wdata_p0  <= req_wdata;
        err_p0    <= req_err;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    resp_err       = 1'b0;
    mem_byteEnable = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (store_p0 && !err_p0) mem_byteEnable = store_be_f(funct3_p0[1:0], addr_p0[1:0]);
        state_nxt = RESP;
      end
      RESP: begin
        // mem_dout stays stable here: the address is held and nothing is written.
        resp_valid = 1'b1;
        resp_err   = err_p0;
        if (!store_p0 && !err_p0) resp_data = load_fmt_f(funct3_p0, addr_p0[1:0], mem_dout);
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr = addr_p0[AW-1:2];
  assign mem_din  = store_din_f(funct3_p0[1:0], wdata_p0);

endmodule

// File: tb/tb_lsu_mem_align.sv
`timescale 1ns/1ps
module tb_lsu_mem_align;

  localparam int AW = 4;
  localparam int NW = 1 << AW;
  localparam int NB = NW * 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_funct3;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [3:0]    mem_byteEnable;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  always #5 clk = ~clk;

  lsu_mem_align #(.ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .mem_byteEnable(mem_byteEnable), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Byte-lane memory with one-cycle synchronous read; not reset by rst_n.
  logic [31:0] mem [NW];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < NW; i++) mem[i] <= '0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (mem_byteEnable[l]) mem[mem_addr][8*l +: 8] <= mem_din[8*l +: 8];
    end
    mem_dout <= mem[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  // Reference model state: memory as a flat byte array.
  logic [7:0] ref_mem [NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Byte-level model of an access: which bytes are touched, what a load returns.
  task automatic model(input bit st, input logic [2:0] f3, input int addr, input logic [31:0] wd,
                       output logic e_err, output logic [31:0] e_data, output logic [3:0] e_be,
                       output logic [31:0] e_din, output int e_wa);
    int     size, off, ea;
    bit     ill;
    longint v;
    ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3[2]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = addr % size;
`ifdef LSU_MISALIGN_TRAP_EN
    e_err = ill || (off != 0);
`else
    e_err = ill;
`endif
    ea     = addr - off;
    e_wa   = ea / 4;
    e_be   = 4'b0000;
    e_din  = '0;
    e_data = '0;
    if (!e_err && st) begin
      for (int i = 0; i < size; i++) begin
        ref_mem[ea+i]    = wd[8*i +: 8];
        e_be[(ea%4)+i]   = 1'b1;
      end
      for (int l = 0; l < 4; l++) e_din[8*l +: 8] = wd[8*(l%size) +: 8];
    end else if (!e_err) begin
      v = 0;
      for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[ea+i]) << (8*i));
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1))) v = v - (longint'(1) << (8*size));
      e_data = v[31:0];
    end
  endtask

  // mode 0: normal; mode 1: hold RESP 5 cycles with a competing request;
  // mode 2: reset asserted during ACCESS (response discarded).
  // The request is presented for one cycle and registered at the closing edge;
  // ACCESS follows that edge and resp_valid follows the next one.
  task automatic do_req(input bit st, input logic [2:0] f3, input int addr, input logic [31:0] wd,
                        input bit use_exp, input logic [31:0] exp_d, input int mode);
    logic        e_err;
    logic [31:0] e_data, e_din;
    logic [3:0]  e_be;
    int          e_wa;
    int          n;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", 32'(req_ready), 32'd1);
    model(st, f3, addr, wd, e_err, e_data, e_be, e_din, e_wa);
    if (use_exp) e_data = exp_d;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = 6'(addr);
    req_wdata  = wd;
    resp_ready = (mode == 0);
    if (mode != 2) q.push_back('{data: e_data, err: e_err});
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = 6'($urandom);
    req_wdata  = $urandom;
    check("access_ready", 32'(req_ready), 32'd0);
    check("access_valid", 32'(resp_valid), 32'd0);
    check("access_be", 32'(mem_byteEnable), 32'(e_be));
    check("access_addr", 32'(mem_addr), 32'(e_wa));
    if (e_be != 4'b0000) check("access_din", mem_din, e_din);
    if (mode == 2) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_acc_ready", 32'(req_ready), 32'd1);
      check("rst_acc_valid", 32'(resp_valid), 32'd0);
      check("rst_acc_data", resp_data, 32'd0);
      check("rst_acc_be", 32'(mem_byteEnable), 32'd0);
      check("rst_acc_addr", 32'(mem_addr), 32'd0);
      check("rst_acc_din", mem_din, 32'd0);
      rst_n = 1'b1;
      return;
    end
    @(posedge clk); #1;
    check("lat_resp", 32'(resp_valid), 32'd1);
    if (mode == 1) begin
      req_valid  = 1'b1;
      req_store  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 6'h08;
      req_wdata  = 32'h0BAD0BAD;
      repeat (5) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_data", resp_data, e_data);
        check("hold_ready", 32'(req_ready), 32'd0);
        check("hold_be", 32'(mem_byteEnable), 32'd0);
        check("hold_addr", 32'(mem_addr), 32'(e_wa));
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("back_idle_ready", 32'(req_ready), 32'd1);
    check("back_idle_valid", 32'(resp_valid), 32'd0);
  endtask

  // Monitor: compares every consumed response against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got data %h err %b, expected no response", resp_data, resp_err);
        end else begin
          mon_e = q.pop_front();
          checks++;
          if (resp_data !== mon_e.data || resp_err !== mon_e.err) begin
            errors++;
            $display("FAIL resp: got data %h err %b, expected data %h err %b",
                     resp_data, resp_err, mon_e.data, mon_e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    mem_clr    = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_data", resp_data, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_be", 32'(mem_byteEnable), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", mem_din, 32'd0);
    rst_n   = 1'b1;
    mem_clr = 1'b0;

    // SW 0x08 -> be 1111, word 2, din DEADBEEF
    do_req(1'b1, 3'b010, 8, 32'hDEADBEEF, 1'b0, 32'h0, 0);
    do_req(1'b0, 3'b000, 11, 32'h0, 1'b1, 32'hFFFFFFDE, 0);
    do_req(1'b0, 3'b100, 11, 32'h0, 1'b1, 32'h000000DE, 0);
    do_req(1'b0, 3'b101, 8, 32'h0, 1'b1, 32'h0000BEEF, 0);
    // SB 0x09 -> be 0010, din 55555555
    do_req(1'b1, 3'b000, 9, 32'h00000055, 1'b0, 32'h0, 0);
    do_req(1'b0, 3'b010, 8, 32'h0, 1'b1, 32'hDEAD55EF, 0);
    // Misaligned SH 0x09: trapped, or aligned down to lanes 0011
    do_req(1'b1, 3'b001, 9, 32'h00001234, 1'b0, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 8, 32'h0, 1'b1, 32'hDEAD55EF, 0);
`else
    do_req(1'b0, 3'b010, 8, 32'h0, 1'b1, 32'hDEAD1234, 0);
`endif
    // Back-pressure with a competing store that must be ignored
    do_req(1'b0, 3'b010, 8, 32'h0, 1'b0, 32'h0, 1);
    do_req(1'b0, 3'b010, 8, 32'h0, 1'b0, 32'h0, 0);
    // Reset during the ACCESS of a store: the write still lands
    do_req(1'b1, 3'b010, 12, 32'hCAFEF00D, 1'b0, 32'h0, 2);
    do_req(1'b0, 3'b010, 12, 32'h0, 1'b1, 32'hCAFEF00D, 0);
    // Illegal codes: store with unsigned width, load with 011
    do_req(1'b1, 3'b101, 16, 32'h12345678, 1'b0, 32'h0, 0);
    do_req(1'b0, 3'b011, 16, 32'h0, 1'b0, 32'h0, 0);
    do_req(1'b0, 3'b010, 16, 32'h0, 1'b0, 32'h0, 0);

    for (int k = 0; k < 80; k++) begin
      do_req(1'($urandom), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, NB-1)),
             $urandom, 1'b0, 32'h0, 0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
